// File: rtl/stage5_msg_sched_pkg.sv
// Shared encodings for the stage-5 message scheduler: type codes, mux controls and FSM states.
package stage5_msg_sched_pkg;

  localparam int MSG_W_DEF  = 32;
  localparam int CTRL_W_DEF = 2;
  localparam int TYPE_W_DEF = 8;

  localparam int unsigned TYPE_CODE_A = 8'h41;
  localparam int unsigned TYPE_CODE_K = 8'h4B;

  localparam int unsigned MUX_NONE = 0;
  localparam int unsigned MUX_A    = 1;
  localparam int unsigned MUX_K    = 2;

  typedef enum logic {
    SCHED_COLLECT = 1'b0,
    SCHED_ISSUE   = 1'b1
  } sched_state_e;

endpackage

// File: rtl/stage5_msg_sched_slot.sv
// One-entry lane buffer: holds a message and its mapped mux control from accept
// until the batch it belongs to retires. Exposes next-state values so the top can capture same-cycle accepts.
module stage5_msg_slot
  import stage5_msg_sched_pkg::*;
#(
  parameter int MSG_W  = MSG_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int TYPE_W = TYPE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              open,
  input  logic              clear,
  input  logic              vld,
  input  logic [MSG_W-1:0]  new_msg,
  input  logic [TYPE_W-1:0] new_type,
  output logic              rdy,
  output logic              full,
  output logic              nxt_full,
  output logic [MSG_W-1:0]  nxt_msg,
  output logic [CTRL_W-1:0] nxt_ctrl
);

  logic [MSG_W-1:0]  msg;
  logic [CTRL_W-1:0] ctrl;
  logic              take;

  // Unknown codes still occupy the slot; they just select no extractor.
  function automatic logic [CTRL_W-1:0] map_type(input logic [TYPE_W-1:0] code);
    if (code == TYPE_W'(TYPE_CODE_A)) return CTRL_W'(MUX_A);
    if (code == TYPE_W'(TYPE_CODE_K)) return CTRL_W'(MUX_K);
    return CTRL_W'(MUX_NONE);
  endfunction

  assign rdy  = ~full & open;
  assign take = vld & rdy;

  always_comb begin
    nxt_full = full;
    nxt_msg  = msg;
    nxt_ctrl = ctrl;
    if (clear) begin
      nxt_full = 1'b0;
      nxt_msg  = '0;
      nxt_ctrl = CTRL_W'(MUX_NONE);
    end else if (take) begin
      nxt_full = 1'b1;
      nxt_msg  = new_msg;
      nxt_ctrl = map_type(new_type);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      msg  <= '0;
      ctrl <= CTRL_W'(MUX_NONE);
    end else begin
      full <= nxt_full;
      msg  <= nxt_msg;
      ctrl <= nxt_ctrl;
    end
  end

endmodule

// File: rtl/stage5_msg_sched.sv
// Stage-5 message scheduler: collects one message per lane and issues all three as one enable beat.
// Define STAGE5_SCHED_TIMEOUT_EN to let a partial batch issue after TIMEOUT cycles without a flush.
module stage5_msg_sched
  import stage5_msg_sched_pkg::*;
#(
  parameter int MSG_W   = MSG_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_1,
  input  logic              in_vld_2,
  input  logic              in_vld_3,
  output logic              in_rdy_1,
  output logic              in_rdy_2,
  output logic              in_rdy_3,
  input  logic [MSG_W-1:0]  in_msg_1,
  input  logic [MSG_W-1:0]  in_msg_2,
  input  logic [MSG_W-1:0]  in_msg_3,
  input  logic [TYPE_W-1:0] in_type_1,
  input  logic [TYPE_W-1:0] in_type_2,
  input  logic [TYPE_W-1:0] in_type_3,
  input  logic              flush,
  input  logic              out_rdy,
  output logic              message_en,
  output logic [MSG_W-1:0]  message_1,
  output logic [MSG_W-1:0]  message_2,
  output logic [MSG_W-1:0]  message_3,
  output logic [CTRL_W-1:0] message_mux_control_m1,
  output logic [CTRL_W-1:0] message_mux_control_m2,
  output logic [CTRL_W-1:0] message_mux_control_m3,
  output logic              busy
);

  sched_state_e      state;
  logic [2:0]        lane_vld;
  logic [2:0]        lane_rdy;
  logic [2:0]        full;
  logic [2:0]        nxt_full;
  logic [MSG_W-1:0]  lane_msg   [3];
  logic [TYPE_W-1:0] lane_type  [3];
  logic [MSG_W-1:0]  nxt_msg    [3];
  logic [CTRL_W-1:0] nxt_ctrl   [3];
  logic [MSG_W-1:0]  batch_msg  [3];
  logic [CTRL_W-1:0] batch_ctrl [3];
  logic              slot_open;
  logic              retire;
  logic              any_full;
  logic              timeout_hit;
  logic              go_issue;

  assign lane_vld     = {in_vld_3, in_vld_2, in_vld_1};
  assign lane_msg[0]  = in_msg_1;
  assign lane_msg[1]  = in_msg_2;
  assign lane_msg[2]  = in_msg_3;
  assign lane_type[0] = in_type_1;
  assign lane_type[1] = in_type_2;
  assign lane_type[2] = in_type_3;

  assign slot_open = (state == SCHED_COLLECT);
  assign retire    = (state == SCHED_ISSUE) & out_rdy;
  assign any_full  = |full;

  for (genvar i = 0; i < 3; i++) begin : g_slot
    stage5_msg_slot #(
      .MSG_W  (MSG_W),
      .CTRL_W (CTRL_W),
      .TYPE_W (TYPE_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .open     (slot_open),
      .clear    (retire),
      .vld      (lane_vld[i]),
      .new_msg  (lane_msg[i]),
      .new_type (lane_type[i]),
      .rdy      (lane_rdy[i]),
      .full     (full[i]),
      .nxt_full (nxt_full[i]),
      .nxt_msg  (nxt_msg[i]),
      .nxt_ctrl (nxt_ctrl[i])
    );
  end

`ifdef STAGE5_SCHED_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] timer;

  // Age of the oldest waiting message; held while a batch is out, saturating at the issue point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == SCHED_ISSUE) begin
      if (out_rdy) timer <= '0;
    end else if (!any_full) begin
      timer <= '0;
    end else if (timer != TIMER_MAX) begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout_hit = (timer == TIMER_MAX) & any_full;
`else
  assign timeout_hit = 1'b0;
`endif

  // Uses post-accept fullness so messages arriving on the completing cycle join the batch.
  assign go_issue = slot_open & ((&nxt_full) | (flush & (|nxt_full)) | timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCHED_COLLECT;
      message_en <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        batch_msg[i]  <= '0;
        batch_ctrl[i] <= CTRL_W'(MUX_NONE);
      end
    end else begin
      case (state)
        SCHED_COLLECT: begin
          if (go_issue) begin
            state      <= SCHED_ISSUE;
            message_en <= 1'b1;
            for (int i = 0; i < 3; i++) begin
              batch_msg[i]  <= nxt_msg[i];
              batch_ctrl[i] <= nxt_ctrl[i];
            end
          end
        end
        SCHED_ISSUE: begin
          if (out_rdy) begin
            state      <= SCHED_COLLECT;
            message_en <= 1'b0;
            for (int i = 0; i < 3; i++) begin
              batch_msg[i]  <= '0;
              batch_ctrl[i] <= CTRL_W'(MUX_NONE);
            end
          end
        end
        default: begin
          state      <= SCHED_COLLECT;
          message_en <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy_1 = lane_rdy[0];
  assign in_rdy_2 = lane_rdy[1];
  assign in_rdy_3 = lane_rdy[2];

  assign message_1              = batch_msg[0];
  assign message_2              = batch_msg[1];
  assign message_3              = batch_msg[2];
  assign message_mux_control_m1 = batch_ctrl[0];
  assign message_mux_control_m2 = batch_ctrl[1];
  assign message_mux_control_m3 = batch_ctrl[2];

  assign busy = any_full | (state == SCHED_ISSUE);

endmodule
